mem_access: RTL and testbench

// - Memory stage: consumes execute-stage results (ALU result as address/passthrough, rs2 as store data).
// - Runs one load or store per accepted op on a req/ack data-memory port.
// - Produces the write-back value, destination register and exception code.
// - Stalls execute via in_ready while a memory transaction is outstanding.

---
 rtl/mem_access_pkg.sv | 39 +++
 rtl/mem_access_load_extend.sv | 27 ++
 rtl/mem_access.sv | 199 +++++++++++++++++++
 tb/tb_mem_access.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory stage: funct3 size codes, exception codes, FSM states.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT  = 2'b10;
  localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

  typedef enum logic [0:0] {
    StIdle,
    StReq
  } state_e;

  function automatic logic load_f3_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic store_f3_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

  // Size is carried in funct3[1:0]; the unsigned flag does not affect alignment.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic res;
    case (f3[1:0])
      2'b01:   res = lo[0];
      2'b10:   res = (lo != 2'b00);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_access_load_extend.sv
// Load lane selection and sign/zero extension of a 32-bit memory word.
module mem_access_load_extend
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Pick the addressed lane, then extend according to the access type.
  always_comb begin
    byte_v = rdata[8*addr_lo +: 8];
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_v[7]}}, byte_v};
      F3_H:    data = {{16{half_v[15]}}, half_v};
      F3_BU:   data = {24'h0, byte_v};
      F3_HU:   data = {16'h0, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory stage: one load/store per accepted op over a req/ack port, with timeout.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic [WIDTH-1:0]   store_data,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [2:0]         funct3,
  input  logic [4:0]         rd,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [WIDTH-1:0]   dmem_addr,
  output logic [WIDTH-1:0]   dmem_wdata,
  output logic [WIDTH/8-1:0] dmem_wstrb,
  input  logic               dmem_ack,
  input  logic [WIDTH-1:0]   dmem_rdata,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [4:0]         out_rd,
  output logic [1:0]         out_exc
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [WIDTH-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0]    wdata_q, wdata_d;
  logic [WIDTH/8-1:0]  wstrb_q, wstrb_d;
  logic [2:0]          f3_q, f3_d;
  logic [1:0]          lo_q, lo_d;
  logic [4:0]          op_rd_q, op_rd_d;
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [4:0]          out_rd_q, out_rd_d;
  logic [1:0]          out_exc_q, out_exc_d;

  logic                is_mem;
  logic                illegal;
  logic                misaligned;
  logic [WIDTH-1:0]    st_wdata;
  logic [WIDTH/8-1:0]  st_wstrb;
  logic [WIDTH-1:0]    load_val;

  mem_access_load_extend u_load_extend (
    .rdata   (dmem_rdata),
    .addr_lo (lo_q),
    .funct3  (f3_q),
    .data    (load_val)
  );

  // Decode the presented op: legality, alignment and store lane/strobe placement.
  always_comb begin
    is_mem     = mem_read | mem_write;
    illegal    = (mem_read & mem_write) |
                 (mem_read & ~load_f3_legal(funct3)) |
                 (mem_write & ~store_f3_legal(funct3));
    misaligned = is_misaligned(funct3, alu_result[1:0]);
    case (funct3[1:0])
      2'b00: begin
        st_wdata = {4{store_data[7:0]}};
        st_wstrb = 4'b0001 << alu_result[1:0];
      end
      2'b01: begin
        st_wdata = {2{store_data[15:0]}};
        st_wstrb = 4'b0011 << alu_result[1:0];
      end
      default: begin
        st_wdata = store_data;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // Next-state and result logic; out_valid defaults low so it only ever pulses.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    f3_d        = f3_q;
    lo_d        = lo_q;
    op_rd_d     = op_rd_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_rd_d    = out_rd_q;
    out_exc_d   = out_exc_q;

    unique case (state_q)
      StIdle: begin
        // Acks arriving here are stale and deliberately ignored.
        if (in_valid) begin
          if (!is_mem) begin
            out_valid_d = 1'b1;
            out_data_d  = alu_result;
            out_rd_d    = rd;
            out_exc_d   = EXC_NONE;
          end else if (illegal) begin
            out_valid_d = 1'b1;
            out_data_d  = '0;
            out_rd_d    = rd;
            out_exc_d   = EXC_ILLEGAL;
          end else if (misaligned) begin
            out_valid_d = 1'b1;
            out_data_d  = '0;
            out_rd_d    = rd;
            out_exc_d   = EXC_MISALIGN;
          end else begin
            state_d = StReq;
            cnt_d   = '0;
            we_d    = mem_write;
            addr_d  = {alu_result[WIDTH-1:2], 2'b00};
            wdata_d = mem_write ? st_wdata : '0;
            wstrb_d = mem_write ? st_wstrb : '0;
            f3_d    = funct3;
            lo_d    = alu_result[1:0];
            op_rd_d = rd;
          end
        end
      end
      StReq: begin
        // Ack takes priority over the timeout on the limiting edge.
        if (dmem_ack) begin
          state_d     = StIdle;
          out_valid_d = 1'b1;
          out_data_d  = we_q ? '0 : load_val;
          out_rd_d    = op_rd_q;
          out_exc_d   = EXC_NONE;
        end else if (cnt_q == CntLast) begin
          state_d     = StIdle;
          out_valid_d = 1'b1;
          out_data_d  = '0;
          out_rd_d    = op_rd_q;
          out_exc_d   = EXC_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset; reset abandons any open request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      f3_q        <= '0;
      lo_q        <= '0;
      op_rd_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_rd_q    <= '0;
      out_exc_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      f3_q        <= f3_d;
      lo_q        <= lo_d;
      op_rd_q     <= op_rd_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_rd_q    <= out_rd_d;
      out_exc_q   <= out_exc_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign dmem_req   = (state_q == StReq);
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_wstrb = wstrb_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_rd     = out_rd_q;
  assign out_exc    = out_exc_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed, table-driven bench for mem_access plus timeout and reset sequences.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        out_valid;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic [1:0]  out_exc;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access #(
    .WIDTH   (32),
    .TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_result (alu_result),
    .store_data (store_data),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .rd         (rd),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_wstrb (dmem_wstrb),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_rd     (out_rd),
    .out_exc    (out_exc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] sd;
    logic        mr;
    logic        mw;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        exp_req;
    int          wait_n;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_data;
    logic [1:0]  exp_exc;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int i);
    @(negedge clk);
    chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'd1);
    chk($sformatf("v%0d out_valid idle", i), 32'(out_valid), 32'd0);
    alu_result = v.alu;
    store_data = v.sd;
    mem_read   = v.mr;
    mem_write  = v.mw;
    funct3     = v.f3;
    rd         = v.rd;
    in_valid   = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (!v.exp_req) begin
      chk($sformatf("v%0d no req", i), 32'(dmem_req), 32'd0);
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d out_data", i), out_data, v.exp_data);
      chk($sformatf("v%0d out_exc", i), 32'(out_exc), 32'(v.exp_exc));
      chk($sformatf("v%0d out_rd", i), 32'(out_rd), 32'(v.rd));
    end else begin
      chk($sformatf("v%0d req", i), 32'(dmem_req), 32'd1);
      chk($sformatf("v%0d addr", i), dmem_addr, v.exp_addr);
      chk($sformatf("v%0d we", i), 32'(dmem_we), 32'(v.exp_we));
      chk($sformatf("v%0d wstrb", i), 32'(dmem_wstrb), 32'(v.exp_strb));
      chk($sformatf("v%0d wdata", i), dmem_wdata, v.exp_wdata);
      chk($sformatf("v%0d in_ready busy", i), 32'(in_ready), 32'd0);
      for (int k = 0; k < v.wait_n; k++) begin
        @(negedge clk);
        chk($sformatf("v%0d req held %0d", i, k), 32'(dmem_req), 32'd1);
        chk($sformatf("v%0d addr held %0d", i, k), dmem_addr, v.exp_addr);
        chk($sformatf("v%0d no early valid %0d", i, k), 32'(out_valid), 32'd0);
      end
      dmem_ack   = 1'b1;
      dmem_rdata = v.rdata;
      @(negedge clk);
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h0;
      chk($sformatf("v%0d req dropped", i), 32'(dmem_req), 32'd0);
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d out_data", i), out_data, v.exp_data);
      chk($sformatf("v%0d out_exc", i), 32'(out_exc), 32'(v.exp_exc));
      chk($sformatf("v%0d out_rd", i), 32'(out_rd), 32'(v.rd));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    //          alu           sd            mr    mw    f3      rd     req   w   rdata         addr          we    strb   wdata         data          exc
    vecs[0]  = '{32'h0000_1234, 32'h0,       1'b0, 1'b0, 3'b111, 5'd5,  1'b0, 0,  32'h0,        32'h0,        1'b0, 4'h0, 32'h0,        32'h0000_1234, 2'b00};
    vecs[1]  = '{32'h0000_0103, 32'h0,       1'b1, 1'b0, 3'b000, 5'd7,  1'b1, 2,  32'h80FF_0000, 32'h100,      1'b0, 4'h0, 32'h0,        32'hFFFF_FF80, 2'b00};
    vecs[2]  = '{32'h0000_0103, 32'h0,       1'b1, 1'b0, 3'b100, 5'd7,  1'b1, 2,  32'h80FF_0000, 32'h100,      1'b0, 4'h0, 32'h0,        32'h0000_0080, 2'b00};
    vecs[3]  = '{32'h0000_0102, 32'hABCD_BEEF, 1'b0, 1'b1, 3'b001, 5'd0, 1'b1, 4, 32'h0,        32'h100,      1'b1, 4'hC, 32'hBEEF_BEEF, 32'h0,        2'b00};
    vecs[4]  = '{32'h0000_0101, 32'h0,       1'b1, 1'b0, 3'b010, 5'd1,  1'b0, 0,  32'h0,        32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        2'b01};
    vecs[5]  = '{32'h0000_0003, 32'h0,       1'b1, 1'b0, 3'b001, 5'd2,  1'b0, 0,  32'h0,        32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        2'b01};
    vecs[6]  = '{32'h0000_0010, 32'h0,       1'b1, 1'b0, 3'b011, 5'd3,  1'b0, 0,  32'h0,        32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        2'b11};
    vecs[7]  = '{32'h0000_0200, 32'h0,       1'b1, 1'b1, 3'b010, 5'd4,  1'b0, 0,  32'h0,        32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        2'b11};
    vecs[8]  = '{32'h0000_0020, 32'h0,       1'b0, 1'b1, 3'b100, 5'd0,  1'b0, 0,  32'h0,        32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        2'b11};
    vecs[9]  = '{32'h0000_0204, 32'h0,       1'b1, 1'b0, 3'b010, 5'd3,  1'b1, 0,  32'hDEAD_BEEF, 32'h204,      1'b0, 4'h0, 32'h0,        32'hDEAD_BEEF, 2'b00};
    vecs[10] = '{32'h0000_0206, 32'h0,       1'b1, 1'b0, 3'b001, 5'd4,  1'b1, 1,  32'h8001_1234, 32'h204,      1'b0, 4'h0, 32'h0,        32'hFFFF_8001, 2'b00};
    vecs[11] = '{32'h0000_0206, 32'h0,       1'b1, 1'b0, 3'b101, 5'd4,  1'b1, 1,  32'h8001_1234, 32'h204,      1'b0, 4'h0, 32'h0,        32'h0000_8001, 2'b00};
    vecs[12] = '{32'h0000_0301, 32'h0000_00A5, 1'b0, 1'b1, 3'b000, 5'd0, 1'b1, 0, 32'h0,        32'h300,      1'b1, 4'h2, 32'hA5A5_A5A5, 32'h0,        2'b00};
    vecs[13] = '{32'h0000_0040, 32'h1122_3344, 1'b0, 1'b1, 3'b010, 5'd0, 1'b1, 15, 32'h0,       32'h040,      1'b1, 4'hF, 32'h1122_3344, 32'h0,        2'b00};
    vecs[14] = '{32'h0000_0000, 32'h0,       1'b1, 1'b0, 3'b000, 5'd6,  1'b1, 1,  32'h1234_5678, 32'h000,      1'b0, 4'h0, 32'h0,        32'h0000_0078, 2'b00};
    vecs[15] = '{32'h0000_0008, 32'h0,       1'b1, 1'b0, 3'b010, 5'd8,  1'b1, 15, 32'hCAFE_F00D, 32'h008,      1'b0, 4'h0, 32'h0,        32'hCAFE_F00D, 2'b00};
    vecs[16] = '{32'h0000_0102, 32'h0,       1'b1, 1'b0, 3'b010, 5'd10, 1'b0, 0,  32'h0,        32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        2'b01};
    vecs[17] = '{32'h0000_0101, 32'h0,       1'b0, 1'b1, 3'b001, 5'd0,  1'b0, 0,  32'h0,        32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        2'b01};
    vecs[18] = '{32'h0000_0010, 32'h0,       1'b1, 1'b0, 3'b110, 5'd11, 1'b0, 0,  32'h0,        32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        2'b11};
    vecs[19] = '{32'h0000_0102, 32'h0,       1'b1, 1'b0, 3'b000, 5'd12, 1'b1, 0,  32'h007F_0000, 32'h100,      1'b0, 4'h0, 32'h0,        32'h0000_007F, 2'b00};

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    alu_result = 32'h0;
    store_data = 32'h0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    funct3     = 3'b000;
    rd         = 5'd0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;

    repeat (2) @(negedge clk);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset dmem_req", 32'(dmem_req), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", out_data, 32'h0);
    chk("reset out_rd", 32'(out_rd), 32'd0);
    chk("reset out_exc", 32'(out_exc), 32'd0);
    chk("reset wstrb", 32'(dmem_wstrb), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Timeout: no ack ever; request must stay up for exactly 16 cycles.
    @(negedge clk);
    alu_result = 32'h0000_0500;
    mem_read   = 1'b1;
    funct3     = 3'b010;
    rd         = 5'd9;
    in_valid   = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    mem_read = 1'b0;
    cnt = 0;
    while (dmem_req === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk("timeout req cycles", 32'(cnt), 32'd16);
    chk("timeout out_valid", 32'(out_valid), 32'd1);
    chk("timeout out_exc", 32'(out_exc), 32'd2);
    chk("timeout out_data", out_data, 32'h0);
    chk("timeout out_rd", 32'(out_rd), 32'd9);
    @(negedge clk);
    chk("timeout pulse single", 32'(out_valid), 32'd0);

    // Reset while a store is outstanding: the op must vanish without a result.
    alu_result = 32'h0000_0600;
    store_data = 32'h0000_0055;
    mem_write  = 1'b1;
    funct3     = 3'b010;
    rd         = 5'd0;
    in_valid   = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    mem_write = 1'b0;
    chk("midrst req up", 32'(dmem_req), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst req dropped", 32'(dmem_req), 32'd0);
    chk("midrst no valid", 32'(out_valid), 32'd0);
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst still no valid", 32'(out_valid), 32'd0);

    // Stray ack while idle must be ignored.
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    chk("stray ack no valid", 32'(out_valid), 32'd0);
    chk("stray ack no req", 32'(dmem_req), 32'd0);
    chk("stray ack in_ready", 32'(in_ready), 32'd1);

    run_vec(vecs[9], 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
